// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: two-entry skid buffer (head + skid) with stall counter.
// Define EX_MEM_FWD_EN to enable the EX->EX forwarding outputs; otherwise they are tied to 0.
module ex_mem_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic        in_rf_we,
  input  logic [4:0]  in_rf_waddr,
  input  logic        in_mem_en,
  input  logic [3:0]  in_mem_we,
  input  logic [31:0] in_mem_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_alu_result,
  output logic        out_rf_we,
  output logic [4:0]  out_rf_waddr,
  output logic        out_mem_en,
  output logic [3:0]  out_mem_we,
  output logic [31:0] out_mem_wdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
  } entry_t;

  entry_t      in_ent;
  entry_t      head_q;
  entry_t      head_d;
  entry_t      skid_q;
  logic        head_valid_q;
  logic        head_valid_d;
  logic        skid_valid_q;
  logic        skid_valid_d;
  logic        head_ld;
  logic        skid_ld;
  logic        accept;
  logic        pop;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  assign in_ent = '{pc:         in_pc,
                    alu_result: in_alu_result,
                    rf_we:      in_rf_we,
                    rf_waddr:   in_rf_waddr,
                    mem_en:     in_mem_en,
                    mem_we:     in_mem_we,
                    mem_wdata:  in_mem_wdata};

  // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign pop      = head_valid_q & out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_ld      = 1'b0;
    skid_ld      = 1'b0;
    head_d       = in_ent;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      head_ld      = 1'b1;
      head_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!head_valid_q || pop)) begin
      head_ld      = 1'b1;
      head_valid_d = 1'b1;
    end else if (accept) begin
      skid_ld      = 1'b1;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      // Payload only moves on a load so idle entries do not toggle.
      if (head_ld) head_q <= head_d;
      if (skid_ld) skid_q <= in_ent;
    end
  end

  assign out_valid      = head_valid_q;
  assign out_pc         = head_q.pc;
  assign out_alu_result = head_q.alu_result;
  assign out_rf_we      = head_q.rf_we;
  assign out_rf_waddr   = head_q.rf_waddr;
  assign out_mem_en     = head_q.mem_en;
  assign out_mem_we     = head_q.mem_we;
  assign out_mem_wdata  = head_q.mem_wdata;
  assign stall_cnt      = stall_cnt_q;

`ifdef EX_MEM_FWD_EN
  entry_t fwd_src;
  logic   fwd_src_valid;

  // Youngest valid entry wins; loads cannot forward since their data is not yet known.
  assign fwd_src       = skid_valid_q ? skid_q : head_q;
  assign fwd_src_valid = skid_valid_q | head_valid_q;
  assign fwd_we        = fwd_src_valid & fwd_src.rf_we & ~(fwd_src.mem_en & ~|fwd_src.mem_we);
  assign fwd_waddr     = fwd_src.rf_waddr;
  assign fwd_wdata     = fwd_src.alu_result;
`else
  assign fwd_we    = 1'b0;
  assign fwd_waddr = 5'd0;
  assign fwd_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reset, flow, backpressure, flush, forwarding, saturation.
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic        in_mem_en;
  logic [3:0]  in_mem_we;
  logic [31:0] in_mem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_alu_result;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic        out_mem_en;
  logic [3:0]  out_mem_we;
  logic [31:0] out_mem_wdata;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  ex_mem_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_rf_we      (in_rf_we),
    .in_rf_waddr   (in_rf_waddr),
    .in_mem_en     (in_mem_en),
    .in_mem_we     (in_mem_we),
    .in_mem_wdata  (in_mem_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_alu_result(out_alu_result),
    .out_rf_we     (out_rf_we),
    .out_rf_waddr  (out_rf_waddr),
    .out_mem_en    (out_mem_en),
    .out_mem_we    (out_mem_we),
    .out_mem_wdata (out_mem_wdata),
    .fwd_we        (fwd_we),
    .fwd_waddr     (fwd_waddr),
    .fwd_wdata     (fwd_wdata),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic we, input logic [4:0] wa, input logic men,
                       input logic [3:0] mwe);
    in_valid      = v;
    in_pc         = pc;
    in_alu_result = alu;
    in_rf_we      = we;
    in_rf_waddr   = wa;
    in_mem_en     = men;
    in_mem_we     = mwe;
    in_mem_wdata  = pc ^ 32'hA5A5_0000;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 4'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_wdata", out_mem_wdata, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_fwd_we", fwd_we, 0);

    // Flow: three back-to-back entries with the sink always ready.
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h11, 1'b1, 5'd1, 1'b0, 4'd0);
    step();
    check("flow0_valid", out_valid, 1);
    check("flow0_pc", out_pc, 32'h100);
    check("flow0_ready", in_ready, 1);
    drive(1'b1, 32'h104, 32'h22, 1'b1, 5'd2, 1'b1, 4'hF);
    step();
    check("flow1_valid", out_valid, 1);
    check("flow1_pc", out_pc, 32'h104);
    check("flow1_mwe", out_mem_we, 4'hF);
    check("flow1_ready", in_ready, 1);
    drive(1'b1, 32'h108, 32'h33, 1'b0, 5'd3, 1'b0, 4'd0);
    step();
    check("flow2_valid", out_valid, 1);
    check("flow2_pc", out_pc, 32'h108);
    check("flow2_alu", out_alu_result, 32'h33);
    check("flow2_ready", in_ready, 1);
    idle();
    step();
    check("flow_drain", out_valid, 0);
    check("flow_stall", stall_cnt, 0);

    // Backpressure: second entry lands in the skid and in_ready drops.
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h44, 1'b1, 5'd4, 1'b0, 4'd0);
    step();
    check("bp0_pc", out_pc, 32'h200);
    check("bp0_ready", in_ready, 1);
    check("bp0_stall", stall_cnt, 0);
    drive(1'b1, 32'h204, 32'h55, 1'b1, 5'd5, 1'b0, 4'd0);
    step();
    check("bp1_ready", in_ready, 0);
    check("bp1_pc", out_pc, 32'h200);
    check("bp1_stall", stall_cnt, 1);
    idle();
    step();
    check("bp2_pc_hold", out_pc, 32'h200);
    check("bp2_wdata_hold", out_mem_wdata, 32'hA5A5_0200);
    check("bp2_stall", stall_cnt, 2);
    out_ready = 1'b1;
    step();
    check("bp3_pc", out_pc, 32'h204);
    check("bp3_valid", out_valid, 1);
    check("bp3_ready", in_ready, 1);
    check("bp3_stall", stall_cnt, 2);
    step();
    check("bp4_valid", out_valid, 0);
    check("bp4_ready", in_ready, 1);

    // Flush with both entries full while 0x300 is offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h280, 32'h66, 1'b1, 5'd6, 1'b0, 4'd0);
    step();
    drive(1'b1, 32'h284, 32'h77, 1'b1, 5'd7, 1'b0, 4'd0);
    step();
    check("fl_full", in_ready, 0);
    check("fl_stall_pre", stall_cnt, 3);
    drive(1'b1, 32'h300, 32'h88, 1'b1, 5'd8, 1'b0, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_stall", stall_cnt, 4);
    out_ready = 1'b1;
    step();
    check("fl_no300", out_valid, 0);

    // Flush with one entry and in_ready=1: offered input still discarded.
    drive(1'b1, 32'h2C0, 32'h99, 1'b0, 5'd9, 1'b0, 4'd0);
    out_ready = 1'b0;
    step();
    drive(1'b1, 32'h300, 32'hAA, 1'b0, 5'd10, 1'b0, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("fl1_valid", out_valid, 0);
    check("fl1_ready", in_ready, 1);

    // Forwarding: head r5=0xDEAD, then a load and an ALU op to r5 in the skid.
    drive(1'b1, 32'h400, 32'hDEAD, 1'b1, 5'd5, 1'b0, 4'd0);
    step();
`ifdef EX_MEM_FWD_EN
    check("fwd_head_we", fwd_we, 1);
    check("fwd_head_addr", fwd_waddr, 5);
    check("fwd_head_data", fwd_wdata, 32'hDEAD);
    drive(1'b1, 32'h404, 32'h1000, 1'b1, 5'd5, 1'b1, 4'd0);
    step();
    check("fwd_load_we", fwd_we, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 32'h400, 32'hDEAD, 1'b1, 5'd5, 1'b0, 4'd0);
    step();
    drive(1'b1, 32'h408, 32'hBEEF, 1'b1, 5'd5, 1'b0, 4'd0);
    step();
    check("fwd_alu_we", fwd_we, 1);
    check("fwd_alu_data", fwd_wdata, 32'hBEEF);
`else
    check("nofwd_we", fwd_we, 0);
    check("nofwd_addr", fwd_waddr, 0);
    check("nofwd_data", fwd_wdata, 0);
    drive(1'b1, 32'h408, 32'hBEEF, 1'b1, 5'd5, 1'b0, 4'd0);
    step();
    check("nofwd_skid_data", fwd_wdata, 0);
`endif
    idle();
    check("pre_rst_full", in_ready, 0);

    // Reset mid-backpressure drops both entries and clears the counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_pc", out_pc, 0);
    check("mrst_alu", out_alu_result, 0);
    check("mrst_rfwe", out_rf_we, 0);
    check("mrst_stall", stall_cnt, 0);
    check("mrst_fwd", fwd_we, 0);

    // Saturation: 70000 stalled edges must stick at 0xFFFF.
    drive(1'b1, 32'h500, 32'h1, 1'b0, 5'd0, 1'b0, 4'd0);
    step();
    idle();
    check("sat_start", stall_cnt, 0);
    repeat (70000) @(posedge clk);
    #1;
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_pc_hold", out_pc, 32'h500);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_after_flush", stall_cnt, 16'hFFFF);
    check("sat_flush_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; reset is sampled only on the rising edge of clk.
REQ-002 SHALL provide port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide port flush, input, 1 bit: discard all held entries (branch/exception).
REQ-005 SHALL provide port in_valid, input, 1 bit: EX result present.
REQ-006 SHALL provide port in_ready, output, 1 bit: block can accept this cycle.
REQ-007 SHALL provide the following input payload ports:
- in_pc, 32 bits: instruction PC.
- in_alu_result, 32 bits: ALU output (result or memory address).
- in_rf_we, 1 bit: register-file write enable.
- in_rf_waddr, 5 bits: destination register.
- in_mem_en, 1 bit: memory access.
- in_mem_we, 4 bits: byte write enables; in_mem_en=1 with in_mem_we=0 marks a load.
- in_mem_wdata, 32 bits: store data.
REQ-008 SHALL provide port out_valid, output, 1 bit: head entry present.
REQ-009 SHALL provide port out_ready, input, 1 bit: MEM stage accepts the head.
REQ-010 SHALL provide output payload ports out_pc, out_alu_result, out_rf_we, out_rf_waddr, out_mem_en, out_mem_we and out_mem_wdata, with the same widths as the inputs in REQ-007.
REQ-011 SHALL provide the following forwarding outputs:
- fwd_we, output, 1 bit.
- fwd_waddr, output, 5 bits.
- fwd_wdata, output, 32 bits.
REQ-012 SHALL provide port stall_cnt, output, 16 bits: count of backpressure cycles.

Function
REQ-013 SHALL hold two entries: a head register that drives the out_* ports, and a skid register.
REQ-014 SHALL drive in_ready = ~skid_valid directly from a register, with no combinational path from out_ready.
REQ-015 SHALL define an accept as in_valid&in_ready and a pop as out_valid&out_ready, both evaluated at the rising edge.
REQ-016 SHALL handle accept and pop combinations as follows:
- Accept, head empty or popping, skid empty: the input loads the head.
- Accept, head full and not popping: the input loads the skid.
- Pop with skid full: the skid moves to the head and the skid empties; no accept is possible that cycle.
REQ-017 SHALL give a latency of 1 cycle from accept to out_valid when the block is empty, and sustain 1 entry/cycle when out_ready is held at 1.
REQ-018 SHALL keep entries in strict FIFO order; no entry is dropped or duplicated except by flush or rst.
REQ-019 SHALL hold all out_* payload signals stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on flush=1, clear both valid bits on the next edge; any input offered that cycle is discarded and any pop is ignored; flush has priority over accept and pop.
REQ-021 SHALL drive in_ready=1 in the cycle after a flush.
REQ-022 SHALL increment stall_cnt by 1 on every edge where out_valid=1 and out_ready=0; stall_cnt saturates at 16'hFFFF and is unaffected by flush.
REQ-023 SHALL make payload registers capture only on load, so that they do not toggle while their entry is idle.

Reset
REQ-024 SHALL, on rst=1 at the edge, clear head_valid, skid_valid, all payload registers and stall_cnt to 0.
REQ-025 SHALL drive the following values in the cycle after reset:
- out_valid=0.
- in_ready=1.
- All out_* signals 0.
- fwd_we=0.
REQ-026 SHALL give rst priority over flush, accept and pop; a reset mid-transfer loses both entries.

Configuration
REQ-027 SHALL, with macro EX_MEM_FWD_EN defined, compute the forwarding outputs as follows:
- Source entry: the skid entry if valid (youngest), else the head entry.
- fwd_we = entry valid & rf_we & ~(mem_en & ~|mem_we).
- fwd_waddr and fwd_wdata are the source entry's rf_waddr and alu_result.
REQ-028 SHALL, with EX_MEM_FWD_EN undefined, tie fwd_we, fwd_waddr and fwd_wdata to 0 and instantiate no forwarding logic.

Verification
REQ-029 Flow test: hold out_ready=1 and send 3 entries with pc 0x100/0x104/0x108 on consecutive cycles; out_valid is observed for 3 consecutive cycles starting 1 cycle after the first accept, in that order, with in_ready=1 throughout.
REQ-030 Backpressure test: hold out_ready=0 and send pc 0x200 then 0x204; in_ready is 0 after the 2nd accept and stall_cnt increments each cycle; then raise out_ready; 0x200 pops, then 0x204 pops, and in_ready returns to 1.
REQ-031 Flush test: with both entries full, pulse flush while also offering pc 0x300; next cycle out_valid=0 and in_ready=1, and 0x300 never appears at the output.
REQ-032 Forwarding test (EX_MEM_FWD_EN defined): head holds rf_we=1, waddr=5, alu_result=0xDEAD; a skid load to r5 gives fwd_we=0; a skid ALU op to r5 with result 0xBEEF gives fwd_wdata=0xBEEF.
REQ-033 Reset and saturation test: assert rst mid-backpressure; outputs and stall_cnt are 0 next cycle; then force 70000 stall cycles; stall_cnt holds at 0xFFFF.
